// File: rtl/live_cell_encoder_pkg.sv
// Shared types for the live-cell encoder: FSM state encoding.
package live_cell_encoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1
  } enc_state_t;

endpackage

// File: rtl/live_cell_encoder_lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit, plus any/onehot flags.
module lowest_set_bit #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         onehot_o
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o    = |vec_i;
  assign onehot_o = any_o && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule

// File: rtl/live_cell_encoder.sv
// Streams the column index of every live cell in a captured row, lowest first,
// over a valid/ready output; reports the row popcount and an empty-row pulse.
module live_cell_encoder
  import live_cell_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ena_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_o,
  output logic         out_last_o,
  output logic [W:0]   count_o,
  output logic         empty_o
);

  enc_state_t  state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;

  logic [W-1:0] lsb_idx;
  logic         lsb_any;
  logic         lsb_onehot;
  logic [W:0]   in_popcnt;
  logic         capture;
  logic         xfer;

  lowest_set_bit #(.N(N)) u_lsb (
    .vec_i    (pending_q),
    .idx_o    (lsb_idx),
    .any_o    (lsb_any),
    .onehot_o (lsb_onehot)
  );

  always_comb begin
    in_popcnt = '0;
    for (int i = 0; i < N; i++) begin
      in_popcnt = in_popcnt + (W + 1)'(in_i[i]);
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_EMIT);
  assign out_o       = out_valid_o ? lsb_idx : '0;
  assign out_last_o  = out_valid_o && lsb_onehot;
  assign count_o     = count_q;
  assign empty_o     = empty_q;

  assign capture = ena_i && in_ready_o && in_valid_i;
  assign xfer    = ena_i && out_valid_o && out_ready_i;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    empty_d   = empty_q;
    // ena low holds everything, including a pulse already in flight.
    if (ena_i) begin
      empty_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (capture) begin
            count_d = in_popcnt;
            if (in_i != '0) begin
              pending_d = in_i;
              state_d   = S_EMIT;
            end else begin
              empty_d = 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (xfer) begin
            // Clearing the lowest set bit; a onehot row drains to zero.
            pending_d = pending_q & (pending_q - 1'b1);
            if (out_last_o || !lsb_any) begin
              pending_d = '0;
              state_d   = S_IDLE;
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          pending_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
    end
  end

endmodule
